// File: rtl/cn_ff_pkg.sv
// Shared constants for the change/no-change flip-flop bank.
// Provides the default reset bit and the named encodings of c.
package cn_ff_pkg;

  localparam logic CN_RESET_BIT = 1'b0;

  localparam logic CN_HOLD = 1'b0;
  localparam logic CN_LOAD = 1'b1;

endpackage

// File: rtl/cn_ff_if.sv
// Data bundle of a WIDTH-bit CN flip-flop bank.
// master drives c/n and observes q/qbar; slave is the flop bank.
interface cn_ff_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;

  modport master (
    output c,
    output n,
    input  q,
    input  qbar
  );

  modport slave (
    input  c,
    input  n,
    output q,
    output qbar
  );

endinterface

// File: rtl/cn_ff_cell.sv
// One-bit CN flip-flop: c=1 loads n, c=0 holds; async high reset.
// Ports: clk, rst, c, n -> q, qbar (qbar = ~q of the same register).
module cn_ff_cell
  import cn_ff_pkg::*;
#(
  parameter logic RST_BIT = CN_RESET_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic c,
  input  logic n,
  output logic q,
  output logic qbar
);

  logic q_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= RST_BIT;
    end else if (c == CN_LOAD) begin
      q_r <= n;
    end
  end

  assign q    = q_r;
  assign qbar = ~q_r;

endmodule

// File: rtl/cn_ff.sv
// WIDTH independent CN flip-flops with per-bit reset value.
// Ports: clk, rst, bus (cn_ff_if.slave: c, n in; q, qbar out).
module cn_ff
  import cn_ff_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{CN_RESET_BIT}}
) (
  input  logic    clk,
  input  logic    rst,
  cn_ff_if.slave  bus
);

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] qbar_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cn_ff_cell #(
      .RST_BIT (RESET_VAL[i])
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .c    (bus.c[i]),
      .n    (bus.n[i]),
      .q    (q_w[i]),
      .qbar (qbar_w[i])
    );
  end

  assign bus.q    = q_w;
  assign bus.qbar = qbar_w;

endmodule

// File: tb/tb_cn_ff.sv
// Self-checking bench for cn_ff: scalar and 4-bit instances.
// Directed vectors plus hand-written async reset sequences.
module tb_cn_ff;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cn_ff_if #(.WIDTH(1)) if1 ();
  cn_ff_if #(.WIDTH(4)) if4 ();

  cn_ff #(
    .WIDTH (1)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  cn_ff #(
    .WIDTH     (4),
    .RESET_VAL (4'b1010)
  ) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic c;
    logic n;
    logic q;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic eq);
    chk({name, ".q"}, {3'b0, if1.q}, {3'b0, eq});
    chk({name, ".qbar"}, {3'b0, if1.qbar}, {3'b0, ~eq});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    if1.c  = 1'b0;
    if1.n  = 1'b0;
    if4.c  = 4'b0;
    if4.n  = 4'b0;

    vecs[0] = '{rst: 1'b1, c: 1'b0, n: 1'b0, q: 1'b0};
    vecs[1] = '{rst: 1'b0, c: 1'b0, n: 1'b0, q: 1'b0};
    vecs[2] = '{rst: 1'b0, c: 1'b0, n: 1'b0, q: 1'b0};
    vecs[3] = '{rst: 1'b0, c: 1'b0, n: 1'b1, q: 1'b0};
    vecs[4] = '{rst: 1'b0, c: 1'b1, n: 1'b1, q: 1'b1};
    vecs[5] = '{rst: 1'b0, c: 1'b0, n: 1'b0, q: 1'b1};
    vecs[6] = '{rst: 1'b0, c: 1'b0, n: 1'b1, q: 1'b1};
    vecs[7] = '{rst: 1'b0, c: 1'b1, n: 1'b0, q: 1'b0};
    vecs[8] = '{rst: 1'b0, c: 1'b1, n: 1'b1, q: 1'b1};

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst   = vecs[i].rst;
      if1.c = vecs[i].c;
      if1.n = vecs[i].n;
      @(posedge clk);
      #1;
      chk1($sformatf("vec%0d", i), vecs[i].q);
    end

    // q=1 here; changes between edges must not reach q
    @(negedge clk);
    if1.c = 1'b1;
    if1.n = 1'b0;
    #2;
    chk1("no_transparency", 1'b1);
    @(posedge clk);
    #1;
    chk1("load0_after_edge", 1'b0);

    // reload 1, then async reset between edges
    @(negedge clk);
    if1.n = 1'b1;
    @(posedge clk);
    #1;
    chk1("reload1", 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("async_rst_immediate", 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("rst_hold_edge%0d", k), 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk1("first_edge_after_rst", 1'b1);

    // 4-bit bank with RESET_VAL 1010
    @(negedge clk);
    rst   = 1'b1;
    if4.c = 4'b0000;
    if4.n = 4'b0000;
    #1;
    chk("w4_rst.q", if4.q, 4'b1010);
    chk("w4_rst.qbar", if4.qbar, 4'b0101);
    @(negedge clk);
    rst   = 1'b0;
    if4.c = 4'b0011;
    if4.n = 4'b0101;
    @(posedge clk);
    #1;
    chk("w4_load.q", if4.q, 4'b1001);
    chk("w4_load.qbar", if4.qbar, 4'b0110);

    // reset raised in the same timestep as a rising edge wins
    @(negedge clk);
    if4.c = 4'b1111;
    if4.n = 4'b0101;
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("w4_rst_vs_edge.q", if4.q, 4'b1010);
    chk("w4_rst_vs_edge.qbar", if4.qbar, 4'b0101);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("w4_load_all.q", if4.q, 4'b0101);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
